// File: rtl/fft_bfly_last_pipe.sv
// Last-stage radix-2 FFT butterfly: two register stages (butterfly, then scale/saturate/reorder)
// with valid/ready handshakes on both sides and a sticky saturation flag.
module fft_bfly_last_pipe #(
  parameter int DW = 16,
  parameter int N  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*2*DW-1:0] in_data,
  input  logic              scale,
  input  logic              bitrev_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*2*DW-1:0] out_data,
  output logic              ovf_flag,
  input  logic              ovf_clr
);

  localparam int LOG2N = $clog2(N);
  localparam int CW    = 2 * DW;

  typedef logic signed [DW:0] ext_t;

  // Sign-extended components of each input sample
  ext_t in_re [N];
  ext_t in_im [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign in_re[k] = {in_data[k*CW+CW-1], in_data[k*CW+DW +: DW]};
    assign in_im[k] = {in_data[k*CW+DW-1], in_data[k*CW +: DW]};
  end

  // Handshake: a stage loads when it is empty or when its content moves on
  logic a_valid;
  logic b_valid;
  logic b_load;
  logic a_moves;
  logic a_load;
  logic in_fire;

  assign b_load    = !b_valid || out_ready;
  assign a_moves   = a_valid && b_load;
  assign a_load    = !a_valid || a_moves;
  assign in_ready  = a_load;
  assign in_fire   = in_valid && a_load;
  assign out_valid = b_valid;

  // Stage A: butterfly results r[2j]=sum, r[2j+1]=difference, one bit of growth
  ext_t a_re [N];
  ext_t a_im [N];
  logic a_scale;
  logic a_bitrev;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
    end else if (a_load) begin
      a_valid <= in_valid;
    end
  end

  // NOTE: the wide datapath registers carry no reset; a_valid qualifies their content.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_scale  <= scale;
      a_bitrev <= bitrev_en;
      for (int j = 0; j < N/2; j++) begin
        a_re[2*j]   <= in_re[2*j] + in_re[2*j+1];
        a_re[2*j+1] <= in_re[2*j] - in_re[2*j+1];
        a_im[2*j]   <= in_im[2*j] + in_im[2*j+1];
        a_im[2*j+1] <= in_im[2*j] - in_im[2*j+1];
      end
    end
  end

  // Returns {clamped, result}: halve with floor, or saturate to DW bits
  function automatic logic [DW:0] scale_sat(input ext_t v, input logic halve);
    logic [DW:0] r;
    if (halve) begin
      r = {1'b0, v[DW:1]};
    end else if (v[DW] != v[DW-1]) begin
      r = {1'b1, v[DW], {(DW-1){~v[DW]}}};
    end else begin
      r = {1'b0, v[DW-1:0]};
    end
    return r;
  endfunction

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

  // Stage B input: scaled/saturated results placed at their output slot
  logic [N*CW-1:0] b_next;
  logic            frame_ovf;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    b_next    = '0;
    frame_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [DW:0]      re_q;
      logic [DW:0]      im_q;
      logic [LOG2N-1:0] dst;
      re_q      = scale_sat(a_re[i], a_scale);
      im_q      = scale_sat(a_im[i], a_scale);
      frame_ovf = frame_ovf | re_q[DW] | im_q[DW];
      dst       = a_bitrev ? bit_rev(LOG2N'(i)) : LOG2N'(i);
      b_next[dst*CW +: CW] = {re_q[DW-1:0], im_q[DW-1:0]};
    end
  end

  // Stage B register plus overflow flag; the set lands one cycle after the load
  logic ovf_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid  <= 1'b0;
      out_data <= '0;
      ovf_pend <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (b_load) begin
        b_valid <= a_valid;
        if (a_valid) begin
          out_data <= b_next;
        end
      end
      ovf_pend <= a_moves && frame_ovf;
      if (ovf_pend) begin
        ovf_flag <= 1'b1;
      end else if (ovf_clr) begin
        ovf_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly_last_pipe.sv
// Self-checking bench for fft_bfly_last_pipe: scoreboard of model frames plus directed
// checks of saturation, floor scaling, ordering, backpressure, reset and the overflow flag.
module tb_fft_bfly_last_pipe;

  localparam int DW    = 16;
  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int CW    = 2 * DW;
  localparam int FW    = N * CW;
  localparam int MAXV  = (1 << (DW-1)) - 1;
  localparam int MINV  = -(1 << (DW-1));

  typedef logic [FW-1:0] frame_t;

  logic   clk;
  logic   rst_n;
  logic   in_valid;
  logic   in_ready;
  frame_t in_data;
  logic   scale;
  logic   bitrev_en;
  logic   out_valid;
  logic   out_ready;
  frame_t out_data;
  logic   ovf_flag;
  logic   ovf_clr;

  int     n_chk  = 0;
  int     n_fail = 0;
  int     n_acc  = 0;
  int     n_out  = 0;
  frame_t sb [$];
  frame_t sb_head;
  frame_t f;
  frame_t got;

  fft_bfly_last_pipe #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .scale     (scale),
    .bitrev_en (bitrev_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf_flag  (ovf_flag),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [FW-1:0] got_v, input logic [FW-1:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  function automatic int rev(input int v);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r = (r << 1) | ((v >> b) & 1);
    return r;
  endfunction

  function automatic int comp(input frame_t d, input int k, input bit is_re);
    logic signed [DW-1:0] t;
    t = is_re ? d[k*CW+DW +: DW] : d[k*CW +: DW];
    return int'(t);
  endfunction

  // Reference: integer butterfly, floor halving or clamping, then slot permutation
  function automatic frame_t model(input frame_t d, input logic sc, input logic br);
    frame_t e = '0;
    for (int i = 0; i < N; i++) begin
      int p = (i / 2) * 2;
      int res [2];
      for (int c = 0; c < 2; c++) begin
        int a = comp(d, p, c == 0);
        int b = comp(d, p + 1, c == 0);
        int r = (i % 2 == 0) ? a + b : a - b;
        if (sc) r = r >>> 1;
        else if (r > MAXV) r = MAXV;
        else if (r < MINV) r = MINV;
        res[c] = r;
      end
      e[(br ? rev(i) : i)*CW +: CW] = {DW'(res[0]), DW'(res[1])};
    end
    return e;
  endfunction

  function automatic logic [CW-1:0] word(input frame_t d, input int k);
    return d[k*CW +: CW];
  endfunction

  function automatic frame_t rand_frame();
    frame_t r;
    for (int k = 0; k < 2*N; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Scoreboard: push the model result at input handshake, compare at output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, scale, bitrev_en));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", FW'(sb.size()), FW'(1));
        end else begin
          sb_head = sb.pop_front();
          check("frame", out_data, sb_head);
        end
        n_out++;
      end
    end
  end

  task automatic send(input frame_t d, input logic sc, input logic br);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = d;
    scale     = sc;
    bitrev_en = br;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", FW'(ok), FW'(1));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    scale     = ~sc;
    bitrev_en = ~br;
  endtask

  task automatic wait_out(output frame_t d);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("out_timeout", FW'(out_valid), FW'(1));
    d = out_data;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    scale     = 1'b0;
    bitrev_en = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", FW'(out_valid), FW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_ovf", FW'(ovf_flag), FW'(0));
    check("rst_in_ready", FW'(in_ready), FW'(1));

    // Saturation versus wrap
    f = '0;
    f[0*CW +: CW] = 32'h7FFF_0000;
    f[1*CW +: CW] = 32'h0001_0000;
    send(f, 1'b0, 1'b1);
    wait_out(got);
    check("sat_out0", FW'(word(got, 0)), FW'(32'h7FFF_0000));
    check("sat_out8", FW'(word(got, 8)), FW'(32'h7FFE_0000));
    @(negedge clk);
    check("sat_ovf_set", FW'(ovf_flag), FW'(1));
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    check("ovf_cleared", FW'(ovf_flag), FW'(0));

    // Same frame halved: never overflows
    send(f, 1'b1, 1'b1);
    wait_out(got);
    check("half_out0", FW'(word(got, 0)), FW'(32'h4000_0000));
    check("half_out8", FW'(word(got, 8)), FW'(32'h3FFF_0000));
    repeat (2) @(negedge clk);
    check("half_ovf_quiet", FW'(ovf_flag), FW'(0));

    // Negative floor and negative saturation
    f = '0;
    f[0*CW +: CW] = 32'h0000_8000;
    f[1*CW +: CW] = 32'h0000_FFFF;
    send(f, 1'b1, 1'b1);
    wait_out(got);
    check("floor_out0", FW'(word(got, 0)), FW'(32'h0000_BFFF));
    check("floor_out8", FW'(word(got, 8)), FW'(32'h0000_C000));
    send(f, 1'b0, 1'b1);
    wait_out(got);
    check("negsat_out0", FW'(word(got, 0)), FW'(32'h0000_8000));
    check("negsat_out8", FW'(word(got, 8)), FW'(32'h0000_8001));
    @(negedge clk);
    check("negsat_ovf", FW'(ovf_flag), FW'(1));

    // Ordering with x[k] = {k,k}
    for (int k = 0; k < N; k++) f[k*CW +: CW] = {DW'(k), DW'(k)};
    send(f, 1'b0, 1'b1);
    wait_out(got);
    check("brev_out0", FW'(word(got, 0)), FW'(32'h0001_0001));
    check("brev_out4", FW'(word(got, 4)), FW'(32'h0005_0005));
    check("brev_out8", FW'(word(got, 8)), FW'(32'hFFFF_FFFF));
    send(f, 1'b0, 1'b0);
    wait_out(got);
    check("nat_out2", FW'(word(got, 2)), FW'(32'h0005_0005));
    check("nat_out3", FW'(word(got, 3)), FW'(32'hFFFF_FFFF));
    repeat (3) @(negedge clk);

    // Backpressure: five frames, output stalled for six cycles
    @(posedge clk); #1 out_ready = 1'b0;
    fork
      begin : drv
        int base_drv;
        base_drv = n_acc;
        @(posedge clk); #1;
        for (int fr = 0; fr < 5; fr++) begin
          bit ok = 1'b0;
          in_valid  = 1'b1;
          in_data   = rand_frame();
          scale     = (fr % 2 == 1);
          bitrev_en = (fr % 3 == 0);
          for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
              ok = 1'b1;
              break;
            end
          end
          check("bp_accept_timeout", FW'(ok), FW'(1));
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_acc_total", FW'(n_acc - base_drv), FW'(5));
      end
      begin : obs
        bit     have = 1'b0;
        frame_t held;
        int     base_acc;
        base_acc = n_acc;
        repeat (6) begin
          @(negedge clk);
          if (out_valid) begin
            if (!have) begin
              held = out_data;
              have = 1'b1;
            end else begin
              check("bp_hold", out_data, held);
            end
          end
        end
        check("bp_two_held", FW'(n_acc - base_acc), FW'(2));
        check("bp_in_ready_low", FW'(in_ready), FW'(0));
        @(posedge clk); #1 out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_stream", FW'(out_valid), FW'(1));
        end
      end
    join
    repeat (3) @(negedge clk);
    check("bp_drained", FW'(sb.size()), FW'(0));

    // Reset with two frames in flight while the flag is set
    check("pre_rst_ovf", FW'(ovf_flag), FW'(1));
    @(posedge clk); #1 out_ready = 1'b0;
    send(rand_frame(), 1'b0, 1'b0);
    send(rand_frame(), 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", FW'(out_valid), FW'(0));
    check("mid_rst_ovf", FW'(ovf_flag), FW'(0));
    check("mid_rst_out_data", out_data, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", FW'(out_valid), FW'(0));

    // Latency after reset, then set-versus-clear priority
    f = '0;
    f[0*CW +: CW] = 32'h7FFF_0000;
    f[1*CW +: CW] = 32'h0001_0000;
    send(f, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_cycle1", FW'(out_valid), FW'(0));
    @(negedge clk);
    check("lat_cycle2", FW'(out_valid), FW'(1));
    ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    check("ovf_set_wins", FW'(ovf_flag), FW'(1));
    @(negedge clk) ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    check("ovf_clr_alone", FW'(ovf_flag), FW'(0));

    repeat (3) @(negedge clk);
    check("sb_empty_end", FW'(sb.size()), FW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bfly_last_pipe.md
Name: fft_bfly_last_pipe

Overview:
Parametrised, pipelined successor to the combinational last-stage radix-2 butterfly of the N-point FFT. It takes one full frame of N complex samples per transfer and computes the twiddle-free butterflies on adjacent pairs (2j, 2j+1). Each result component is either scaled by 1/2 or saturated, and the frame is emitted in bit-reversed or natural order. It sits between the final twiddle stage and the FFT output buffer, with valid/ready handshakes on both sides and a sticky overflow flag.

Parameters:
DW, 16, width of each real/imag component (signed two's complement); complex word = 2*DW bits.
N, 16, points per frame; power of two, 4..64; LOG2N = log2(N).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  frame valid on in_data
in_ready  output  1  block can accept a frame this cycle
in_data  input  N*2*DW  sample k at [k*2*DW +: 2*DW]; real in upper DW bits, imag in lower DW bits
scale  input  1  1: halve results; 0: full scale with saturation; sampled with frame
bitrev_en  input  1  1: bit-reversed output order; 0: natural order; sampled with frame
out_valid  output  1  result frame valid
out_ready  input  1  downstream accepts frame
out_data  output  N*2*DW  result frame, same packing as in_data
ovf_flag  output  1  sticky: some component saturated since last clear
ovf_clr  input  1  synchronous clear of ovf_flag

Behaviour:
- Reset (async, rst_n=0): all pipeline valid bits 0; out_valid=0; out_data=0; ovf_flag=0; in_ready=1 once reset is released.
- Two register stages, A (butterfly) and B (scale/saturate/reorder). Latency is 2 cycles from input handshake to out_valid with out_ready held high. Throughput is 1 frame per cycle.
- Input handshake: a frame is accepted when in_valid && in_ready. scale and bitrev_en are captured with the frame and travel with it; later changes never affect frames already in flight.
- Flow control:
  - Stage B loads when it is empty or when out_ready=1 (B fires).
  - Stage A loads when it is empty or when A moves into B.
  - in_ready = !A_valid || A_moves; combinational from out_ready, no skid buffer.
  - With out_ready=0, two frames are held, after which in_ready=0. No frame is dropped or duplicated, and order is preserved.
- Out handshake: out_data stays stable while out_valid && !out_ready.
- Stage A arithmetic, per pair j in 0..N/2-1, separately for real and imag:
  - s = x[2j] + x[2j+1]
  - d = x[2j] - x[2j+1]
  - Both computed sign-extended to DW+1 bits; no wrap.
- Stage B arithmetic:
  - scale=1: result = value >>> 1 (arithmetic shift, floor, no rounding). Always fits DW bits; no overflow is ever flagged.
  - scale=0: result is saturated to [-2^(DW-1), 2^(DW-1)-1]. Each clamped component marks the frame as overflowed.
- Ordering: butterfly results r[2j]=s_j and r[2j+1]=d_j.
  - bitrev_en=1: out[bitrev_LOG2N(i)] = r[i]. For N=16, r[1] goes to out[8] and r[2] goes to out[4].
  - bitrev_en=0: out[i] = r[i].
- ovf_flag:
  - Set on the cycle after stage B loads an overflowed frame.
  - Cleared by ovf_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - The flag is not cleared by frame boundaries.
- Reset mid-operation: in-flight frames are discarded, with no partial output. The first frame after reset follows the normal 2-cycle latency.

Test Plan:
- Wrap vs saturate (DW=16, N=16, scale=0, bitrev_en=1, others 0): x0={7FFF,0000}, x1={0001,0000} -> out0={7FFF,0000}, out8={7FFE,0000}; ovf_flag=1 one cycle after the B load.
- Same frame with scale=1 -> out0={4000,0000}, out8={3FFF,0000}; ovf_flag unchanged from its prior value.
- Negative floor: x0.imag=8000, x1.imag=FFFF, scale=1 -> out0.imag=BFFF, out8.imag=C000; with scale=0 -> out0.imag=8000 (saturated), ovf set.
- Ordering: x[k] = {k,k} for all k, scale=0.
  - bitrev_en=1 -> out[bitrev(2j)] = {4j+1, 4j+1} and out[bitrev(2j+1)] = {FFFF, FFFF}.
  - bitrev_en=0 -> out[2j] = {4j+1, 4j+1} and out[2j+1] = {FFFF, FFFF}.
- Backpressure: stream 5 frames with in_valid=1 while out_ready=0 for 6 cycles.
  - After frame 2 is accepted, in_ready=0.
  - The first output is held stable until out_ready=1.
  - All 5 frames then emerge in order on consecutive cycles; scale/bitrev_en toggled per frame are honoured.
- Reset/ovf: assert rst_n=0 with 2 frames in flight -> out_valid=0 and ovf_flag=0 immediately. Later, ovf_clr=1 in the same cycle as a new set -> ovf_flag stays 1; ovf_clr alone -> 0.
